// File: rtl/argmax_16_16.sv
// Streaming argmax: takes N signed elements over a valid/ready handshake and
// returns the index of the largest one, with ties going to the lowest index.
module argmax_16_16 #(
    parameter int T = 16,
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_valid,
    input  logic         m_ready,
    input  logic [T-1:0] data_in,
    output logic         m_valid,
    output logic         s_ready,
    output logic [T-1:0] data_out
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] best_idx_q;
    logic [CW-1:0] best_idx_d;
    logic [T-1:0]  best_val_q;
    logic [T-1:0]  best_val_d;
    logic [T-1:0]  data_out_q;
    logic          m_valid_q;
    logic          s_ready_s;
    logic          take_s;
    logic          greater_s;

    // Ready is derived only from registered state, never from m_ready or s_valid.
    assign s_ready_s = ~m_valid_q;
    assign take_s    = s_valid & s_ready_s;
    assign greater_s = $signed(data_in) > $signed(best_val_q);

    assign m_valid  = m_valid_q;
    assign s_ready  = s_ready_s;
    assign data_out = data_out_q;

    // Running maximum if the element on data_in is accepted this cycle.
    always_comb begin
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        if (cnt_q == {CW{1'b0}}) begin
            best_val_d = data_in;
            best_idx_d = {CW{1'b0}};
        end else if (greater_s) begin
            // Strict compare keeps the earlier index on ties.
            best_val_d = data_in;
            best_idx_d = cnt_q;
        end else begin
            best_val_d = best_val_q;
            best_idx_d = best_idx_q;
        end
    end

    // Handshake FSM: accumulate a vector, then hold the result until taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ACCUM;
            cnt_q      <= {CW{1'b0}};
            best_val_q <= {T{1'b0}};
            best_idx_q <= {CW{1'b0}};
            data_out_q <= {T{1'b0}};
            m_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (take_s) begin
                        best_val_q <= best_val_d;
                        best_idx_q <= best_idx_d;
                        if (cnt_q == LAST_IDX) begin
                            data_out_q <= T'(best_idx_d);
                            m_valid_q  <= 1'b1;
                            cnt_q      <= {CW{1'b0}};
                            state_q    <= OUTPUT;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                OUTPUT: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= ACCUM;
                    end
                end
                default: begin
                    state_q   <= ACCUM;
                    cnt_q     <= {CW{1'b0}};
                    m_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_argmax_16_16.sv
// Bench for argmax_16_16: directed vectors with literal expectations plus a
// cycle-by-cycle reference model and a randomised streaming scoreboard.
module tb_argmax_16_16;
    localparam int NV  = 833;
    localparam int TOT = NV * 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic        m_ready;
    logic [15:0] data_in;
    logic        m_valid;
    logic        s_ready;
    logic [15:0] data_out;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    bit rec_en = 1'b0;

    bit          exp_mv;
    logic [15:0] exp_do;
    logic [15:0] mq[$];
    logic [15:0] ma[16];
    logic [15:0] dut_res[$];

    logic [15:0] vec[16];
    logic [15:0] rv[TOT];
    int          rexp[NV];

    always #5 clk = ~clk;

    argmax_16_16 #(.T(16), .N(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .s_valid  (s_valid),
        .m_ready  (m_ready),
        .data_in  (data_in),
        .m_valid  (m_valid),
        .s_ready  (s_ready),
        .data_out (data_out)
    );

    function automatic int argmax16(input logic [15:0] a[16]);
        int b = 0;
        for (int i = 1; i < 16; i++) begin
            if ($signed(a[i]) > $signed(a[b])) b = i;
        end
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timed_out(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Reference model: a vector buffer and a pending-result flag.
    initial begin
        exp_mv = 1'b0;
        exp_do = 16'd0;
        forever begin
            @(posedge clk);
            if (reset) begin
                mq.delete();
                exp_mv = 1'b0;
                exp_do = 16'd0;
            end else if (exp_mv) begin
                if (m_ready) exp_mv = 1'b0;
            end else if (s_valid) begin
                mq.push_back(data_in);
                if (mq.size() == 16) begin
                    for (int i = 0; i < 16; i++) ma[i] = mq[i];
                    exp_do = 16'(argmax16(ma));
                    exp_mv = 1'b1;
                    mq.delete();
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("m_valid", 32'(m_valid), 32'(exp_mv));
                check("s_ready", 32'(s_ready), 32'(!exp_mv));
                check("data_out", 32'(data_out), 32'(exp_do));
                if (rec_en && m_valid && m_ready) dut_res.push_back(data_out);
            end
        end
    end

    task automatic send_elem(input logic [15:0] v);
        bit was_rdy;
        int guard = 0;
        s_valid = 1'b1;
        data_in = v;
        do begin
            was_rdy = s_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!was_rdy && guard < 64);
        if (!was_rdy) timed_out("send_elem");
        s_valid = 1'b0;
        data_in = 16'($urandom);
    endtask

    task automatic run_vec(input string name, input int exp_idx);
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_elem(vec[i]);
        check({name, "_mvalid"}, 32'(m_valid), 32'd1);
        check({name, "_idx"}, 32'(data_out), 32'(exp_idx));
        check({name, "_model"}, 32'(exp_do), 32'(exp_idx));
        @(posedge clk);
        #1;
        check({name, "_drained"}, 32'(m_valid), 32'd0);
        check({name, "_sready"}, 32'(s_ready), 32'd1);
    endtask

    initial begin
        int k;
        int cyc;
        bit was_rdy;

        reset   = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        data_in = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        check("reset_mvalid", 32'(m_valid), 32'd0);
        check("reset_sready", 32'(s_ready), 32'd1);
        check("reset_dout", 32'(data_out), 32'd0);

        for (int i = 0; i < 16; i++) vec[i] = 16'(i);
        run_vec("ramp", 15);

        for (int i = 0; i < 16; i++) vec[i] = 16'h8000;
        run_vec("all_min", 0);

        for (int i = 0; i < 16; i++) vec[i] = 16'hFFFF;
        vec[3] = 16'h0007;
        vec[9] = 16'h0007;
        run_vec("tie", 3);

        for (int i = 0; i < 16; i++) vec[i] = 16'($urandom);
        vec[0] = 16'h7FFF;
        run_vec("first_max", 0);

        for (int i = 0; i < 16; i++) vec[i] = 16'h0000;
        vec[15] = 16'h7FFF;
        run_vec("last_max", 15);

        // Reset mid-vector, with a tempting element offered on the reset edge.
        m_ready = 1'b1;
        for (int i = 0; i < 7; i++) send_elem(16'(i + 100));
        reset   = 1'b1;
        s_valid = 1'b1;
        data_in = 16'h7FFF;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        s_valid = 1'b0;
        check("midreset_mvalid", 32'(m_valid), 32'd0);
        check("midreset_sready", 32'(s_ready), 32'd1);
        for (int i = 0; i < 16; i++) vec[i] = 16'(i * 3 - 20);
        vec[5] = 16'h0100;
        run_vec("post_reset", 5);

        // Hold a result under backpressure, then reset on the accepting edge.
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_elem(16'(i));
        for (int c = 0; c < 5; c++) begin
            check("hold_mvalid", 32'(m_valid), 32'd1);
            check("hold_idx", 32'(data_out), 32'd15);
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        reset   = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        m_ready = 1'b0;
        check("rst_vs_xfer_mvalid", 32'(m_valid), 32'd0);
        check("rst_vs_xfer_sready", 32'(s_ready), 32'd1);
        check("rst_vs_xfer_dout", 32'(data_out), 32'd0);

        // Random streaming with random handshakes on both sides.
        for (int v = 0; v < NV; v++) begin
            for (int i = 0; i < 16; i++) begin
                vec[i] = 16'($urandom);
                rv[v * 16 + i] = vec[i];
            end
            rexp[v] = argmax16(vec);
        end
        dut_res.delete();
        rec_en = 1'b1;
        k   = 0;
        cyc = 0;
        while (dut_res.size() < NV && cyc < 90000) begin
            m_ready = 1'($urandom_range(0, 1));
            if (k < TOT) begin
                s_valid = 1'($urandom_range(0, 1));
                data_in = rv[k];
            end else begin
                s_valid = 1'b0;
                data_in = 16'($urandom);
            end
            was_rdy = s_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (s_valid && was_rdy) k++;
        end
        if (cyc >= 90000) timed_out("random_stream");
        s_valid = 1'b0;
        m_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rec_en = 1'b0;
        check("rand_elems_sent", 32'(k), 32'(TOT));
        check("rand_result_count", 32'(dut_res.size()), 32'(NV));
        for (int v = 0; v < NV; v++) begin
            if (v < dut_res.size()) check("rand_idx", 32'(dut_res[v]), 32'(rexp[v]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/argmax_16_16.md
ARGMAX_16_16 -- requirements
Module: argmax_16_16

Interface
REQ-001 Parameter T, default 16, data word width in bits (input and output).
REQ-002 Parameter N, default 16, elements per vector; equals the output count of the upstream layer stage.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on posedge clk.
REQ-005 s_valid  input  1  upstream element valid.
REQ-006 m_ready  input  1  downstream ready to accept result.
REQ-007 data_in  input  T  signed two's-complement element from upstream layer.
REQ-008 m_valid  output  1  result word valid.
REQ-009 s_ready  output  1  block can accept an element this cycle.
REQ-010 data_out  output  T  index of the maximum element, zero-extended to T bits.
REQ-011 Port order SHALL be clk, reset, s_valid, m_ready, data_in, m_valid, s_ready, data_out, drop-in compatible with the layer stage handshake.

Function
REQ-012 Element transfer SHALL occur only on a posedge where s_valid && s_ready; result transfer only where m_valid && m_ready.
REQ-013 Two states: ACCUM (collecting elements) and OUTPUT (holding result).
REQ-014 In ACCUM: s_ready=1, m_valid=0; in OUTPUT: s_ready=0, m_valid=1 (s_ready = !m_valid, registered-state-derived, no combinational path from m_ready or s_valid).
REQ-015 Element counter cnt, width ceil(log2 N), counts accepted elements 0..N-1 in ACCUM; increments only on transfer.
REQ-016 On transfer with cnt==0: best_val <= data_in, best_idx <= 0 unconditionally.
REQ-017 On transfer with cnt>0: if data_in > best_val (signed, strict) then best_val <= data_in, best_idx <= cnt; else hold.
REQ-018 Ties SHALL resolve to the lowest index (strict compare).
REQ-019 On transfer with cnt==N-1: apply REQ-017 rule, set data_out to the final best index, cnt <= 0, go to OUTPUT.
REQ-020 Latency: m_valid SHALL rise on the posedge immediately after the edge that accepts element N-1 (one cycle).
REQ-021 In OUTPUT, data_out and m_valid SHALL hold stable until the result transfer; m_ready low for any number of cycles SHALL NOT alter them.
REQ-022 On result transfer: state <= ACCUM; s_ready=1 from the next cycle; peak throughput one vector per N+1 cycles.
REQ-023 s_valid low cycles mid-vector SHALL NOT change cnt, best_val or best_idx.
REQ-024 data_in SHALL be ignored (may be X) whenever no transfer occurs.
REQ-025 Comparisons SHALL be full T-bit signed; most-negative value (0x8000 at T=16) is a legal element.

Reset
REQ-026 On reset high at a posedge: state <= ACCUM, cnt <= 0, m_valid <= 0, data_out <= 0, best_val <= 0, best_idx <= 0; s_ready=1 from the following cycle.
REQ-027 Reset SHALL take priority over any simultaneous transfer; partially accumulated vector or pending result is discarded.
REQ-028 After reset, the next accepted element is element 0 of a new vector.

Verification
REQ-029 Elements 0..15 = 0,1,...,15, s_valid and m_ready always high -> data_out=15, m_valid high exactly 1 cycle after element 15 accepted, next vector accepted the cycle after.
REQ-030 Elements all 0x8000 (most negative) -> data_out=0; elements with 0x0007 at indices 3 and 9, rest 0xFFFF -> data_out=3 (tie rule).
REQ-031 Element 0=0x7FFF, rest random -> data_out=0; element 15=0x7FFF, rest 0x0000 -> data_out=15.
REQ-032 Random s_valid/m_ready (50% each, reseeded per cycle), 833 vectors of 16 random signed words -> 833 results matching a reference argmax, no drops or duplicates, data_out stable while m_valid && !m_ready.
REQ-033 Assert reset after 7 elements accepted -> m_valid stays 0; next 16 elements (index 5 max=0x0100) -> data_out=5.
REQ-034 Reset asserted while m_valid=1 and m_ready=1 same edge -> no result counted, m_valid=0 next cycle, s_ready=1.
